pipeline_hazard_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage ARM pipeline.
- Inputs: ID-stage source-register info, EXE/MEM destination info, the EXE branch decision and the MEM-stage SRAM handshake.
- Outputs: the `hazard` input of the ID stage, plus `freeze`/`flush` for the IF, ID/EX, EX/MEM and MEM/WB stage registers.
- Internals: a memory-wait FSM with timeout and a saturating stall-cycle counter for performance visibility.

---
 rtl/pipeline_hazard_controller_if.sv | 42 ++++
 rtl/pipeline_hazard_controller.sv | 114 +++++++++++
 tb/tb_pipeline_hazard_controller.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle of hazard-controller signals: ID/EXE/MEM operand info and SRAM handshake in,
// stall/flush controls and status out.
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       id_src1;
    logic [3:0]       id_src2;
    logic             id_two_src;
    logic             id_ignore_hazard;
    logic [3:0]       exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_read;
    logic [3:0]       mem_dest;
    logic             mem_wb_en;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             stat_clr;
    logic             hazard;
    logic             freeze_if;
    logic             flush_if;
    logic             freeze_pipe;
    logic             flush_id;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_src1, id_src2, id_two_src, id_ignore_hazard,
        output exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
        output branch_taken, mem_req, mem_ready, stat_clr,
        input  hazard, freeze_if, flush_if, freeze_pipe, flush_id,
        input  mem_timeout, stall_count
    );

    modport slave (
        input  id_src1, id_src2, id_two_src, id_ignore_hazard,
        input  exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
        input  branch_taken, mem_req, mem_ready, stat_clr,
        output hazard, freeze_if, flush_if, freeze_pipe, flush_id,
        output mem_timeout, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW detection, memory-wait FSM with
// timeout, branch flush arbitration and a saturating stall-cycle counter.
module pipeline_hazard_controller #(
    parameter bit FWD_EN   = 1'b1,
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 16
) (
    input logic                          clk,
    input logic                          rst,
    pipeline_hazard_controller_if.slave  bus
);
    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic m1_s, m2_s, n1_s, n2_s;
    logic hazard_raw_s, mem_stall_s, freeze_pipe_s, hazard_s, freeze_if_s, flush_s;

    // Hazard detection and stall/flush arbitration from current state and inputs
    always_comb begin
        m1_s = (bus.id_src1 == bus.exe_dest) && bus.exe_wb_en;
        m2_s = bus.id_two_src && (bus.id_src2 == bus.exe_dest) && bus.exe_wb_en;
        n1_s = (bus.id_src1 == bus.mem_dest) && bus.mem_wb_en;
        n2_s = bus.id_two_src && (bus.id_src2 == bus.mem_dest) && bus.mem_wb_en;
        if (FWD_EN) begin
            // With forwarding only a load result is not yet available to bypass
            hazard_raw_s = (m1_s || m2_s) && bus.exe_mem_read && !bus.id_ignore_hazard;
        end else begin
            hazard_raw_s = (m1_s || m2_s || n1_s || n2_s) && !bus.id_ignore_hazard;
        end
        mem_stall_s   = bus.mem_req && !bus.mem_ready;
        freeze_pipe_s = (state_q == TIMEOUT) ? 1'b1 : mem_stall_s;
        hazard_s      = hazard_raw_s && !bus.branch_taken && !freeze_pipe_s;
        freeze_if_s   = freeze_pipe_s || hazard_s;
        flush_s       = bus.branch_taken && !freeze_pipe_s;
    end

    // Memory-wait FSM next state and saturating stall counter
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            RUN: begin
                if (mem_stall_s) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WCW'(1);
                end else begin
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (!bus.mem_req || bus.mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d       = TIMEOUT;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            TIMEOUT: begin
                mem_timeout_d = 1'b1;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (bus.stat_clr) begin
            stall_count_d = '0;
        end else if (freeze_if_s && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.hazard      = hazard_s;
    assign bus.freeze_if   = freeze_if_s;
    assign bus.flush_if    = flush_s;
    assign bus.freeze_pipe = freeze_pipe_s;
    assign bus.flush_id    = flush_s;
    assign bus.mem_timeout = mem_timeout_q;
    assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two configurations driven by shared stimulus,
// checked every cycle against a rule-level model plus hand-computed expectations.
module tb_pipeline_hazard_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [3:0] id_src1 = 4'd0, id_src2 = 4'd0, exe_dest = 4'd0, mem_dest = 4'd0;
    logic id_two_src = 1'b0, id_ignore_hazard = 1'b0, exe_wb_en = 1'b0, exe_mem_read = 1'b0;
    logic mem_wb_en = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0, stat_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Configuration 0: no forwarding, short timeout, narrow counter. Configuration 1: defaults.
    int MAXW[2] = '{4, 64};
    int CMAX[2] = '{15, 65535};
    bit FWD[2]  = '{1'b0, 1'b1};

    bit tmo_m[2];
    int run_m[2];
    int sc_m[2];

    pipeline_hazard_controller_if #(.CNT_W(4))  if0 ();
    pipeline_hazard_controller_if #(.CNT_W(16)) if1 ();

    assign {if0.id_src1, if0.id_src2, if0.id_two_src, if0.id_ignore_hazard, if0.exe_dest,
            if0.exe_wb_en, if0.exe_mem_read, if0.mem_dest, if0.mem_wb_en, if0.branch_taken,
            if0.mem_req, if0.mem_ready, if0.stat_clr} =
           {id_src1, id_src2, id_two_src, id_ignore_hazard, exe_dest, exe_wb_en, exe_mem_read,
            mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready, stat_clr};
    assign {if1.id_src1, if1.id_src2, if1.id_two_src, if1.id_ignore_hazard, if1.exe_dest,
            if1.exe_wb_en, if1.exe_mem_read, if1.mem_dest, if1.mem_wb_en, if1.branch_taken,
            if1.mem_req, if1.mem_ready, if1.stat_clr} =
           {id_src1, id_src2, id_two_src, id_ignore_hazard, exe_dest, exe_wb_en, exe_mem_read,
            mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready, stat_clr};

    pipeline_hazard_controller #(.FWD_EN(1'b0), .MAX_WAIT(4), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    pipeline_hazard_controller #(.FWD_EN(1'b1), .MAX_WAIT(64), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave));

    always #5 clk = ~clk;

    // Expected {hazard, freeze_if, flush_if, freeze_pipe, flush_id} for configuration k
    function automatic logic [4:0] model_comb(input int k);
        bit exe_hit, mem_hit, raw, stall, fp, hz;
        exe_hit = exe_wb_en && (id_src1 == exe_dest || (id_two_src && id_src2 == exe_dest));
        mem_hit = mem_wb_en && (id_src1 == mem_dest || (id_two_src && id_src2 == mem_dest));
        raw     = FWD[k] ? (exe_hit && exe_mem_read) : (exe_hit || mem_hit);
        raw     = raw && !id_ignore_hazard;
        stall   = mem_req && !mem_ready;
        fp      = tmo_m[k] ? 1'b1 : stall;
        hz      = raw && !branch_taken && !fp;
        return {hz, fp || hz, branch_taken && !fp, fp, branch_taken && !fp};
    endfunction

    // Model state advance: timeout after MAX_WAIT consecutive stalled cycles
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [4:0] o;
            int run_n;
            o = model_comb(k);
            if (!rst) begin
                tmo_m[k] <= 1'b0;
                run_m[k] <= 0;
                sc_m[k]  <= 0;
            end else begin
                run_n = (mem_req && !mem_ready && !tmo_m[k]) ? run_m[k] + 1 : 0;
                run_m[k] <= run_n;
                if (run_n >= MAXW[k]) tmo_m[k] <= 1'b1;
                if (stat_clr) sc_m[k] <= 0;
                else if (o[3] && sc_m[k] < CMAX[k]) sc_m[k] <= sc_m[k] + 1;
            end
        end
        if (!rst) started <= 1'b1;
    end

    // Per-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                logic [5:0] act, exp;
                int act_sc;
                if (k == 0) begin
                    act = {if0.hazard, if0.freeze_if, if0.flush_if, if0.freeze_pipe,
                           if0.flush_id, if0.mem_timeout};
                    act_sc = int'(if0.stall_count);
                end else begin
                    act = {if1.hazard, if1.freeze_if, if1.flush_if, if1.freeze_pipe,
                           if1.flush_id, if1.mem_timeout};
                    act_sc = int'(if1.stall_count);
                end
                exp = {model_comb(k), tmo_m[k]};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL outputs dut%0d t=%0t actual=%b required=%b", k, $time, act, exp);
                end
                checks++;
                if (act_sc != sc_m[k]) begin
                    errors++;
                    $display("FAIL stall_count dut%0d t=%0t actual=%0d required=%0d",
                             k, $time, act_sc, sc_m[k]);
                end
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {id_src1, id_src2, exe_dest, mem_dest} = 16'd0;
        {id_two_src, id_ignore_hazard, exe_wb_en, exe_mem_read, mem_wb_en} = 5'd0;
        {branch_taken, mem_req, mem_ready, stat_clr} = 4'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        step(1);
        rst = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        step(2);
        lit("reset_sc0", int'(if0.stall_count), 0);
        lit("reset_tmo0", int'(if0.mem_timeout), 0);
        lit("reset_freeze0", int'(if0.freeze_if), 0);

        // 1: RAW on exe_dest, no forwarding stalls; forwarding config does not
        rst = 1'b1;
        id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
        #1;
        lit("t1_hazard0", int'(if0.hazard), 1);
        lit("t1_freeze_if0", int'(if0.freeze_if), 1);
        lit("t1_flush_id0", int'(if0.flush_id), 0);
        lit("t1_hazard1", int'(if1.hazard), 0);
        step(3);
        lit("t1_sc0", int'(if0.stall_count), 3);
        lit("t1_sc1", int'(if1.stall_count), 0);
        id_ignore_hazard = 1'b1;
        #1;
        lit("t1_ignore0", int'(if0.hazard), 0);
        step(1);

        // 2: forwarding config stalls only on load-use through exe_dest
        clear_inputs();
        id_src2 = 4'd5; id_two_src = 1'b1; exe_dest = 4'd5; exe_wb_en = 1'b1;
        #1;
        lit("t2_noload1", int'(if1.hazard), 0);
        exe_mem_read = 1'b1;
        #1;
        lit("t2_load1", int'(if1.hazard), 1);
        step(2);
        exe_wb_en = 1'b0; mem_dest = 4'd5; mem_wb_en = 1'b1;
        #1;
        lit("t2_memonly1", int'(if1.hazard), 0);
        lit("t2_memonly0", int'(if0.hazard), 1);
        step(2);

        // 3: four wait cycles then ready
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            lit("t3_freeze_pipe1", int'(if1.freeze_pipe), 1);
            lit("t3_freeze_if1", int'(if1.freeze_if), 1);
            step(1);
        end
        mem_ready = 1'b1;
        #1;
        lit("t3_ready_freeze1", int'(if1.freeze_pipe), 0);
        lit("t3_tmo0_after4", int'(if0.mem_timeout), 1);
        step(1);
        mem_req = 1'b0; mem_ready = 1'b0;
        lit("t3_tmo1", int'(if1.mem_timeout), 0);
        step(1);

        // 4: timeout on the short-timeout config, then reset recovers
        do_reset();
        mem_req = 1'b1;
        step(3);
        lit("t4_tmo0_early", int'(if0.mem_timeout), 0);
        step(1);
        lit("t4_tmo0", int'(if0.mem_timeout), 1);
        mem_ready = 1'b1;
        #1;
        lit("t4_freeze0_held", int'(if0.freeze_pipe), 1);
        step(3);
        lit("t4_tmo0_sticky", int'(if0.mem_timeout), 1);
        lit("t4_tmo1", int'(if1.mem_timeout), 0);
        do_reset();
        lit("t4_rst_tmo0", int'(if0.mem_timeout), 0);
        lit("t4_rst_freeze0", int'(if0.freeze_if), 0);
        lit("t4_rst_sc0", int'(if0.stall_count), 0);

        // 5: branch beats RAW; memory stall defers the flush
        id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
        branch_taken = 1'b1;
        #1;
        lit("t5_flush_if0", int'(if0.flush_if), 1);
        lit("t5_flush_id1", int'(if1.flush_id), 1);
        lit("t5_hazard0", int'(if0.hazard), 0);
        step(1);
        mem_req = 1'b1;
        #1;
        lit("t5_stall_flush0", int'(if0.flush_if), 0);
        step(2);
        mem_ready = 1'b1;
        #1;
        lit("t5_ready_flush0", int'(if0.flush_id), 1);
        step(1);

        // 6: counter saturation and clear priority
        do_reset();
        id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
        step(20);
        lit("t6_sat0", int'(if0.stall_count), 15);
        lit("t6_cnt1", int'(if1.stall_count), 20);
        stat_clr = 1'b1;
        step(1);
        lit("t6_clr0", int'(if0.stall_count), 0);
        lit("t6_clr1", int'(if1.stall_count), 0);
        stat_clr = 1'b0;
        step(1);
        lit("t6_restart0", int'(if0.stall_count), 1);
        clear_inputs();
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
